// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb: reservation station that snoops several result buses and issues through one output register.
// Define RS_OLDEST_FIRST_EN to issue the oldest READY entry (age matrix); otherwise the lowest-index READY entry issues.
module rs_multi_cdb #(
    parameter int OPERANDS      = 2,
    parameter int RS_OFFSET     = 0,
    parameter int RS_DEPTH      = 8,
    parameter int RS_ID_WIDTH   = 5,
    parameter int CDB_COUNT     = 2,
    parameter int CONTROL_WIDTH = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             take_valid_i,
    output logic                             take_ready_o,
    input  logic [OPERANDS-1:0]              op_value_valid_i,
    input  logic [OPERANDS*RS_ID_WIDTH-1:0]  op_rs_id_i,
    input  logic [OPERANDS*32-1:0]           op_value_i,
    input  logic [CONTROL_WIDTH-1:0]         control_i,
    output logic [RS_ID_WIDTH-1:0]           id_taken_o,
    input  logic [CDB_COUNT-1:0]             cdb_valid_i,
    input  logic [CDB_COUNT*RS_ID_WIDTH-1:0] cdb_rs_id_i,
    input  logic [CDB_COUNT*32-1:0]          cdb_value_i,
    output logic                             output_valid_o,
    input  logic                             output_ready_i,
    output logic [OPERANDS*32-1:0]           op_value_o,
    output logic [CONTROL_WIDTH-1:0]         control_o,
    output logic [RS_ID_WIDTH-1:0]           op_rs_id_o
);
    localparam int IDX_W = $clog2(RS_DEPTH);

    typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_ISSUED} slot_state_e;

    slot_state_e              state_q [RS_DEPTH];
    slot_state_e              state_d [RS_DEPTH];
    logic [OPERANDS-1:0]      opv_q   [RS_DEPTH];
    logic [OPERANDS-1:0]      opv_d   [RS_DEPTH];
    logic [31:0]              opval_q [RS_DEPTH][OPERANDS];
    logic [31:0]              opval_d [RS_DEPTH][OPERANDS];
    logic [RS_ID_WIDTH-1:0]   optag_q [RS_DEPTH][OPERANDS];
    logic [RS_ID_WIDTH-1:0]   optag_d [RS_DEPTH][OPERANDS];
    logic [CONTROL_WIDTH-1:0] ctrl_q  [RS_DEPTH];
    logic [CONTROL_WIDTH-1:0] ctrl_d  [RS_DEPTH];

    logic                     out_valid_q, out_valid_d;
    logic [OPERANDS*32-1:0]   out_val_q, out_val_d;
    logic [CONTROL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
    logic [RS_ID_WIDTH-1:0]   out_id_q, out_id_d;
    logic [IDX_W-1:0]         out_idx_q, out_idx_d;

    logic                     free_found, sel_found;
    logic [IDX_W-1:0]         free_idx, sel_idx;
    logic [RS_DEPTH-1:0]      ready_vec;
    logic                     take_fire, load_en, free_fire;

    // Lowest-index valid bus whose tag matches wins; bit 32 flags a hit.
    function automatic logic [32:0] cdb_lookup(input logic [RS_ID_WIDTH-1:0] tag);
        logic [32:0] hit;
        hit = '0;
        for (int j = CDB_COUNT - 1; j >= 0; j--) begin
            if (cdb_valid_i[j] && (cdb_rs_id_i[j*RS_ID_WIDTH +: RS_ID_WIDTH] == tag))
                hit = {1'b1, cdb_value_i[j*32 +: 32]};
        end
        return hit;
    endfunction

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (state_q[i] == S_FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < RS_DEPTH; i++)
            ready_vec[i] = (state_q[i] == S_READY);
    end

    assign take_ready_o = free_found;
    assign id_taken_o   = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(free_idx);
    assign take_fire    = take_valid_i && free_found;
    assign load_en      = !out_valid_q || output_ready_i;
    assign free_fire    = out_valid_q && output_ready_i;

`ifdef RS_OLDEST_FIRST_EN
    // age_q[i] holds the set of entries taken before entry i that are still live.
    logic [RS_DEPTH-1:0] age_q [RS_DEPTH];
    logic [RS_DEPTH-1:0] age_d [RS_DEPTH];
    logic [RS_DEPTH-1:0] occ_vec;

    always_comb begin
        occ_vec = '0;
        for (int i = 0; i < RS_DEPTH; i++)
            occ_vec[i] = (state_q[i] != S_FREE);
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i] && !(|(age_q[i] & ready_vec))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        age_d = age_q;
        if (free_fire) begin
            age_d[out_idx_q] = '0;
            for (int j = 0; j < RS_DEPTH; j++)
                age_d[j][out_idx_q] = 1'b0;
        end
        if (take_fire) begin
            age_d[free_idx] = occ_vec;
            if (free_fire)
                age_d[free_idx][out_idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RS_DEPTH; i++)
                age_q[i] <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        logic [32:0] hit;
        hit     = '0;
        state_d = state_q;
        opv_d   = opv_q;
        opval_d = opval_q;
        optag_d = optag_q;
        ctrl_d  = ctrl_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (state_q[i] == S_WAIT) begin
                for (int k = 0; k < OPERANDS; k++) begin
                    if (!opv_q[i][k]) begin
                        hit = cdb_lookup(optag_q[i][k]);
                        if (hit[32]) begin
                            opv_d[i][k]   = 1'b1;
                            opval_d[i][k] = hit[31:0];
                        end
                    end
                end
                if (&opv_d[i])
                    state_d[i] = S_READY;
            end
        end
        // A missing operand may be satisfied by a bus broadcasting in the same cycle as the take.
        if (take_fire) begin
            for (int k = 0; k < OPERANDS; k++) begin
                optag_d[free_idx][k] = op_rs_id_i[k*RS_ID_WIDTH +: RS_ID_WIDTH];
                hit = cdb_lookup(op_rs_id_i[k*RS_ID_WIDTH +: RS_ID_WIDTH]);
                if (op_value_valid_i[k]) begin
                    opv_d[free_idx][k]   = 1'b1;
                    opval_d[free_idx][k] = op_value_i[k*32 +: 32];
                end else begin
                    opv_d[free_idx][k]   = hit[32];
                    opval_d[free_idx][k] = hit[31:0];
                end
            end
            ctrl_d[free_idx]  = control_i;
            state_d[free_idx] = (&opv_d[free_idx]) ? S_READY : S_WAIT;
        end
        if (load_en && sel_found)
            state_d[sel_idx] = S_ISSUED;
        if (free_fire)
            state_d[out_idx_q] = S_FREE;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_val_d   = out_val_q;
        out_ctrl_d  = out_ctrl_q;
        out_id_d    = out_id_q;
        out_idx_d   = out_idx_q;
        if (load_en) begin
            out_valid_d = sel_found;
            if (sel_found) begin
                for (int k = 0; k < OPERANDS; k++)
                    out_val_d[k*32 +: 32] = opval_q[sel_idx][k];
                out_ctrl_d = ctrl_q[sel_idx];
                out_id_d   = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(sel_idx);
                out_idx_d  = sel_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                state_q[i] <= S_FREE;
                opv_q[i]   <= '0;
                ctrl_q[i]  <= '0;
                for (int k = 0; k < OPERANDS; k++) begin
                    opval_q[i][k] <= '0;
                    optag_q[i][k] <= '0;
                end
            end
            out_valid_q <= 1'b0;
            out_val_q   <= '0;
            out_ctrl_q  <= '0;
            out_id_q    <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            opv_q       <= opv_d;
            opval_q     <= opval_d;
            optag_q     <= optag_d;
            ctrl_q      <= ctrl_d;
            out_valid_q <= out_valid_d;
            out_val_q   <= out_val_d;
            out_ctrl_q  <= out_ctrl_d;
            out_id_q    <= out_id_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign output_valid_o = out_valid_q;
    assign op_value_o     = out_val_q;
    assign control_o      = out_ctrl_q;
    assign op_rs_id_o     = out_id_q;

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Bench for rs_multi_cdb: directed scenarios then random traffic, checked against a slot-level reference model.
// Issue order follows RS_OLDEST_FIRST_EN when defined (oldest by take sequence), else lowest index.
module tb_rs_multi_cdb;
    localparam int OPS  = 2;
    localparam int OFF  = 8;
    localparam int DEP  = 8;
    localparam int IDW  = 5;
    localparam int CDBN = 2;
    localparam int CW   = 16;

    localparam int ST_FREE   = 0;
    localparam int ST_WAIT   = 1;
    localparam int ST_READY  = 2;
    localparam int ST_ISSUED = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              take_valid, take_ready;
    logic [OPS-1:0]    op_vv;
    logic [OPS*IDW-1:0] op_tag;
    logic [OPS*32-1:0] op_val;
    logic [CW-1:0]     ctrl;
    logic [IDW-1:0]    id_taken;
    logic [CDBN-1:0]   cdb_v;
    logic [CDBN*IDW-1:0] cdb_id;
    logic [CDBN*32-1:0] cdb_val;
    logic              out_valid, out_ready;
    logic [OPS*32-1:0] out_vals;
    logic [CW-1:0]     out_ctrl;
    logic [IDW-1:0]    out_id;

    always #5 clk = ~clk;

    rs_multi_cdb #(
        .OPERANDS(OPS), .RS_OFFSET(OFF), .RS_DEPTH(DEP),
        .RS_ID_WIDTH(IDW), .CDB_COUNT(CDBN), .CONTROL_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .take_valid_i(take_valid), .take_ready_o(take_ready),
        .op_value_valid_i(op_vv), .op_rs_id_i(op_tag), .op_value_i(op_val),
        .control_i(ctrl), .id_taken_o(id_taken),
        .cdb_valid_i(cdb_v), .cdb_rs_id_i(cdb_id), .cdb_value_i(cdb_val),
        .output_valid_o(out_valid), .output_ready_i(out_ready),
        .op_value_o(out_vals), .control_o(out_ctrl), .op_rs_id_o(out_id)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model: per-slot lifecycle plus the issue register contents
    int          m_st   [DEP];
    bit          m_has  [DEP][OPS];
    logic [31:0] m_val  [DEP][OPS];
    logic [4:0]  m_tag  [DEP][OPS];
    logic [15:0] m_ctrl [DEP];
    int          m_seq  [DEP];
    int          seq_cnt;
    bit          m_ov;
    logic [63:0] m_oval;
    logic [15:0] m_octrl;
    logic [4:0]  m_oid;
    int          m_oslot;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < DEP; i++) begin
            m_st[i] = ST_FREE;
            m_seq[i] = 0;
            for (int k = 0; k < OPS; k++) m_has[i][k] = 1'b0;
        end
        seq_cnt = 0;
        m_ov = 1'b0; m_oval = '0; m_octrl = '0; m_oid = '0; m_oslot = 0;
    endtask

    function automatic logic [32:0] bus_hit(input logic [4:0] tag);
        logic [32:0] r;
        r = '0;
        for (int j = 0; j < CDBN; j++)
            if (!r[32] && cdb_v[j] && cdb_id[j*IDW +: IDW] == tag) r = {1'b1, cdb_val[j*32 +: 32]};
        return r;
    endfunction

    task automatic model_step(input int fs);
        int old_st [DEP];
        bit load, all_ok;
        int pick;
        logic [32:0] h;
        if (rst) begin
            m_reset();
            return;
        end
        old_st = m_st;
        load = !m_ov || out_ready;
        pick = -1;
        if (load)
            for (int i = 0; i < DEP; i++)
                if (old_st[i] == ST_READY) begin
`ifdef RS_OLDEST_FIRST_EN
                    if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
                    if (pick < 0) pick = i;
`endif
                end
        for (int i = 0; i < DEP; i++)
            if (old_st[i] == ST_WAIT) begin
                all_ok = 1'b1;
                for (int k = 0; k < OPS; k++) begin
                    if (!m_has[i][k]) begin
                        h = bus_hit(m_tag[i][k]);
                        if (h[32]) begin m_has[i][k] = 1'b1; m_val[i][k] = h[31:0]; end
                    end
                    all_ok = all_ok && m_has[i][k];
                end
                if (all_ok) m_st[i] = ST_READY;
            end
        if (take_valid && fs >= 0) begin
            all_ok = 1'b1;
            for (int k = 0; k < OPS; k++) begin
                m_tag[fs][k] = op_tag[k*IDW +: IDW];
                h = bus_hit(op_tag[k*IDW +: IDW]);
                if (op_vv[k]) begin m_has[fs][k] = 1'b1; m_val[fs][k] = op_val[k*32 +: 32]; end
                else begin m_has[fs][k] = h[32]; m_val[fs][k] = h[31:0]; end
                all_ok = all_ok && m_has[fs][k];
            end
            m_ctrl[fs] = ctrl;
            m_seq[fs] = seq_cnt++;
            m_st[fs] = all_ok ? ST_READY : ST_WAIT;
        end
        if (m_ov && out_ready) m_st[m_oslot] = ST_FREE;
        if (load) begin
            m_ov = (pick >= 0);
            if (pick >= 0) begin
                m_st[pick] = ST_ISSUED;
                m_oval = {m_val[pick][1], m_val[pick][0]};
                m_octrl = m_ctrl[pick];
                m_oid = 5'(OFF + pick);
                m_oslot = pick;
            end
        end
    endtask

    // one clock: check comb outputs before the edge, advance the model, check registered outputs after
    task automatic step();
        int fs;
        #1;
        fs = -1;
        for (int i = DEP - 1; i >= 0; i--) if (m_st[i] == ST_FREE) fs = i;
        chk("take_ready", take_ready, (fs >= 0));
        chk("id_taken", id_taken, (fs >= 0) ? 5'(OFF + fs) : 5'(OFF));
        model_step(fs);
        @(posedge clk);
        #1;
        chk("output_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("op_value_out", out_vals, m_oval);
            chk("control_out", out_ctrl, m_octrl);
            chk("op_rs_id_out", out_id, m_oid);
        end
    endtask

    task automatic set_idle();
        take_valid = 1'b0; op_vv = '0; op_tag = '0; op_val = '0; ctrl = '0;
        cdb_v = '0; cdb_id = '0; cdb_val = '0;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        set_idle();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_vals", out_vals, 64'd0);
        chk("rst_id", out_id, 5'd0);
        chk("rst_ctrl", out_ctrl, 16'd0);

        // all operands valid: two-edge latency
        take_valid = 1'b1; op_vv = 2'b11; op_val = {32'd7, 32'd5}; ctrl = 16'h0101;
        #1 chk("t1_id_taken", id_taken, 5'd8);
        step();
        chk("t1_not_yet", out_valid, 1'b0);
        set_idle();
        step();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_vals", out_vals, {32'd7, 32'd5});
        chk("t1_id", out_id, 5'd8);
        step();

        // op2 arrives on bus 1 two cycles after the take
        take_valid = 1'b1; op_vv = 2'b01; op_val = {32'd0, 32'd1}; op_tag = {5'd3, 5'd0};
        step();
        set_idle(); step();
        cdb_v = 2'b10; cdb_id = {5'd3, 5'd0}; cdb_val = {32'hAA, 32'h0};
        step();
        chk("t2_wait", out_valid, 1'b0);
        set_idle(); step();
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_vals", out_vals, {32'hAA, 32'd1});
        step();

        // same-cycle bypass from bus 0
        take_valid = 1'b1; op_vv = 2'b10; op_tag = {5'd0, 5'd4}; op_val = {32'd2, 32'd0};
        cdb_v = 2'b01; cdb_id = {5'd0, 5'd4}; cdb_val = {32'h0, 32'h11};
        step();
        set_idle(); step();
        chk("t3_valid", out_valid, 1'b1);
        chk("t3_vals", out_vals, {32'd2, 32'h11});
        step();

        // both buses carry the same tag: bus 0 wins
        take_valid = 1'b1; op_vv = 2'b10; op_tag = {5'd0, 5'd6}; op_val = {32'd3, 32'd0};
        step();
        set_idle();
        cdb_v = 2'b11; cdb_id = {5'd6, 5'd6}; cdb_val = {32'h33, 32'h22};
        step();
        set_idle(); step();
        chk("t4_prio", out_vals, {32'd3, 32'h22});
        step(); step();

        // ID 8 waiting, ID 9 ready first: 9 issues first in either build
        take_valid = 1'b1; op_vv = 2'b10; op_tag = {5'd0, 5'd20}; op_val = {32'd4, 32'd0};
        step();
        op_vv = 2'b11; op_val = {32'd6, 32'd5};
        step();
        set_idle(); step();
        chk("t5_first", out_id, 5'd9);
        cdb_v = 2'b01; cdb_id = {5'd0, 5'd20}; cdb_val = {32'h0, 32'h55};
        step();
        set_idle(); step();
        chk("t5_second", out_id, 5'd8);
        step();

        // slot 0 reused after slot 1, then both become ready together
        take_valid = 1'b1; op_vv = 2'b10; op_tag = {5'd0, 5'd20}; op_val = {32'd1, 32'd0};
        step();
        op_tag = {5'd0, 5'd21};
        step();
        set_idle();
        cdb_v = 2'b01; cdb_id = {5'd0, 5'd20}; cdb_val = {32'h0, 32'h66};
        step();
        set_idle(); step(); step();
        take_valid = 1'b1; op_vv = 2'b10; op_tag = {5'd0, 5'd22}; op_val = {32'd2, 32'd0};
        step();
        set_idle();
        cdb_v = 2'b11; cdb_id = {5'd22, 5'd21}; cdb_val = {32'h77, 32'h88};
        step();
        set_idle(); step();
`ifdef RS_OLDEST_FIRST_EN
        chk("t6_order", out_id, 5'd9);
`else
        chk("t6_order", out_id, 5'd8);
`endif
        step(); step(); step();

        // fill all slots while the unit stalls
        out_ready = 1'b0;
        for (int n = 0; n < DEP; n++) begin
            take_valid = 1'b1; op_vv = 2'b11;
            op_val = {32'(n + 100), 32'(n)}; ctrl = 16'(n);
            step();
        end
        set_idle();
        #1 chk("full_take_ready", take_ready, 1'b0);
        take_valid = 1'b1; op_vv = 2'b11; op_val = {32'hDEAD, 32'hBEEF};
        step();
        set_idle(); out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk("release_ready", take_ready, 1'b1);
        chk("release_id", id_taken, 5'd8);

        // reset while entries are held
        chk("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_valid", out_valid, 1'b0);
        chk("rst2_ready", take_ready, 1'b1);
        chk("rst2_id", id_taken, 5'd8);
        chk("rst2_vals", out_vals, 64'd0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            take_valid = ($urandom_range(0, 1) == 1);
            op_vv = 2'($urandom_range(0, 3));
            op_tag = {5'($urandom_range(OFF, OFF + DEP - 1)), 5'($urandom_range(OFF, OFF + DEP - 1))};
            op_val = {$urandom(), $urandom()};
            ctrl = 16'($urandom());
            cdb_v = 2'($urandom_range(0, 3));
            cdb_id = {5'($urandom_range(OFF, OFF + DEP - 1)), 5'($urandom_range(OFF, OFF + DEP - 1))};
            cdb_val = {$urandom(), $urandom()};
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
